// File: rtl/datapath_ctrl.sv
// datapath_ctrl: decoded IDLE/T1/T2/T3 control sequencer for the 8-register bus datapath.
// Define DATAPATH_CTRL_PREFETCH_EN to add a one-entry instruction buffer for zero-bubble issue.
module datapath_ctrl #(
  parameter int NREG = 8,
  parameter int OPW  = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [8:0]        instr,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [OPW-1:0]    op,
  output logic [2*NREG-1:0] reg_sig,
  output logic              data_in,
  output logic              A_in,
  output logic              G_in,
  output logic              G_out
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_T1   = 2'd1;
  localparam logic [1:0] S_T2   = 2'd2;
  localparam logic [1:0] S_T3   = 2'd3;
  logic [1:0] state_q, state_d;
  logic [8:0] ir_q, ir_d;
  logic [2:0] opc, rx, ry;
  logic       alu, t1, t2, t3, last, take, pend;
  logic       rx_in, rx_out, ry_out;
  assign opc  = ir_q[8:6];
  assign rx   = ir_q[5:3];
  assign ry   = ir_q[2:0];
  assign alu  = opc >= 3'd2 && opc <= 3'd5;
  assign t1   = state_q == S_T1;
  assign t2   = state_q == S_T2;
  assign t3   = state_q == S_T3;
  assign last = (t1 && !alu) || t3;
  assign take = run && ready;
`ifdef DATAPATH_CTRL_PREFETCH_EN
  logic [8:0] buf_q, buf_d;
  logic       bv_q, bv_d;
  assign pend  = bv_q;
  assign ready = state_q == S_IDLE || !bv_q;
  always_comb begin
    buf_d = buf_q;
    bv_d  = bv_q;
    if (state_q == S_IDLE || last) bv_d = 1'b0;
    else if (take) begin
      buf_d = instr;
      bv_d  = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      buf_q <= '0;
      bv_q  <= 1'b0;
    end else begin
      buf_q <= buf_d;
      bv_q  <= bv_d;
    end
`else
  assign pend  = 1'b0;
  assign ready = state_q == S_IDLE;
`endif
  // A buffered instruction wins over a fresh one; ready is low whenever the buffer is full.
  always_comb begin
    state_d = state_q + 2'd1;
    ir_d    = ir_q;
    if (state_q == S_IDLE || last) begin
      state_d = (pend || take) ? S_T1 : S_IDLE;
`ifdef DATAPATH_CTRL_PREFETCH_EN
      ir_d    = bv_q ? buf_q : take ? instr : ir_q;
`else
      ir_d    = take ? instr : ir_q;
`endif
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  assign done    = last;
  assign err     = t1 && opc == 3'b111;
  assign data_in = t1 && opc == 3'b000;
  assign A_in    = t1 && alu;
  assign G_in    = t2 && alu;
  assign G_out   = t3 && alu;
  assign op      = (state_q != S_IDLE && alu) ? OPW'(opc[1:0] - 2'b10) : '0;
  assign rx_in   = (t1 && (opc == 3'b000 || opc == 3'b001)) || t3;
  assign rx_out  = t1 && (alu || opc == 3'b110);
  assign ry_out  = (t1 && opc == 3'b001) || t2;
  always_comb begin
    reg_sig = '0;
    for (int k = 0; k < NREG; k++) begin
      reg_sig[2*NREG-1-2*k] = rx_in && rx == 3'(k);
      reg_sig[2*NREG-2-2*k] = (rx_out && rx == 3'(k)) || (ry_out && ry == 3'(k));
    end
  end
endmodule
